// File: rtl/rv_isa_pkg.sv
// RV32 opcode constants, instruction field positions and the register-usage
// decode helpers shared by the front-end stages.
package rv_isa_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP || opcode == STORE || opcode == BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode, input logic [4:0] rd);
    return !(opcode == STORE || opcode == BRANCH) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits with set-over-clear priority and three
// writeback-aware pending lookups.
module reg_scoreboard #(
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en_i,
  input  logic [REG_NUM_BIT-1:0] set_idx_i,
  input  logic                   wb_clr_en_i,
  input  logic [REG_NUM_BIT-1:0] wb_clr_idx_i,
  input  logic                   fl_clr_en_i,
  input  logic [REG_NUM_BIT-1:0] fl_clr_idx_i,
  input  logic [REG_NUM_BIT-1:0] look_a_i,
  input  logic [REG_NUM_BIT-1:0] look_b_i,
  input  logic [REG_NUM_BIT-1:0] look_c_i,
  output logic                   pend_a_o,
  output logic                   pend_b_o,
  output logic                   pend_c_o
);

  logic [REG_NUM-1:0] pending_q, pending_d;

  // A register being written back this cycle is no longer a hazard.
  function automatic logic eff_pending(input logic [REG_NUM_BIT-1:0] idx);
    return pending_q[idx] && !(wb_clr_en_i && wb_clr_idx_i == idx);
  endfunction

  assign pend_a_o = eff_pending(look_a_i);
  assign pend_b_o = eff_pending(look_b_i);
  assign pend_c_o = eff_pending(look_c_i);

  always_comb begin
    pending_d = pending_q;
    if (wb_clr_en_i) pending_d[wb_clr_idx_i] = 1'b0;
    if (fl_clr_en_i) pending_d[fl_clr_idx_i] = 1'b0;
    if (set_en_i)    pending_d[set_idx_i]    = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: reads rs1/rs2 with writeback bypass, stalls on
// RAW/WAW via the scoreboard and holds the result in one output register.
module operand_fetch
  import rv_isa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned REG_NUM_BIT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [DATA_WIDTH-1:0]  in_pc,
  output logic [REG_NUM_BIT-1:0] rf_raddr_a,
  output logic [REG_NUM_BIT-1:0] rf_raddr_b,
  input  logic [DATA_WIDTH-1:0]  rf_rdata_a,
  input  logic [DATA_WIDTH-1:0]  rf_rdata_b,
  input  logic                   wb_wen,
  input  logic [REG_NUM_BIT-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]  wb_wdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_pc,
  output logic [DATA_WIDTH-1:0]  out_rs1_val,
  output logic [DATA_WIDTH-1:0]  out_rs2_val,
  output logic [31:0]            out_instr,
  output logic [REG_NUM_BIT-1:0] out_rd,
  output logic                   out_rd_wen
);

  logic [6:0]             opcode;
  logic [REG_NUM_BIT-1:0] rs1, rs2, rd;
  logic                   use1, use2, rd_wen;
  logic                   pend1, pend2, pendd, hazard, accept;
  logic [DATA_WIDTH-1:0]  rs1_val, rs2_val;

  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  pc_q, rs1_val_q, rs2_val_q;
  logic [31:0]            instr_q;
  logic [REG_NUM_BIT-1:0] rd_q;
  logic                   rd_wen_q;

  assign opcode = in_instr[OPCODE_LSB +: 7];
  assign rs1    = in_instr[RS1_LSB +: REG_NUM_BIT];
  assign rs2    = in_instr[RS2_LSB +: REG_NUM_BIT];
  assign rd     = in_instr[RD_LSB +: REG_NUM_BIT];
  assign use1   = uses_rs1(opcode);
  assign use2   = uses_rs2(opcode);
  assign rd_wen = writes_rd(opcode, rd);

  assign rf_raddr_a = rs1;
  assign rf_raddr_b = rs2;

  function automatic logic [DATA_WIDTH-1:0] sel_operand(
    input logic [REG_NUM_BIT-1:0] rs, input logic [DATA_WIDTH-1:0] rf);
    if (rs == '0)                      return '0;
    else if (wb_wen && wb_waddr == rs) return wb_wdata;
    else                               return rf;
  endfunction

  assign rs1_val = sel_operand(rs1, rf_rdata_a);
  assign rs2_val = sel_operand(rs2, rf_rdata_b);

  reg_scoreboard #(
    .REG_NUM     (REG_NUM),
    .REG_NUM_BIT (REG_NUM_BIT)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_en_i     (accept && rd_wen),
    .set_idx_i    (rd),
    .wb_clr_en_i  (wb_wen && wb_waddr != '0),
    .wb_clr_idx_i (wb_waddr),
    .fl_clr_en_i  (flush && valid_q && rd_wen_q),
    .fl_clr_idx_i (rd_q),
    .look_a_i     (rs1),
    .look_b_i     (rs2),
    .look_c_i     (rd),
    .pend_a_o     (pend1),
    .pend_b_o     (pend2),
    .pend_c_o     (pendd)
  );

  assign hazard   = (use1 && pend1) || (use2 && pend2) || (rd_wen && pendd);
  assign in_ready = !hazard && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (accept)                  valid_d = 1'b1;
    else if (out_ready || flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      instr_q   <= '0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q      <= in_pc;
        rs1_val_q <= rs1_val;
        rs2_val_q <= rs2_val;
        instr_q   <= in_instr;
        rd_q      <= rd;
        rd_wen_q  <= rd_wen;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_instr   = instr_q;
  assign out_rd      = rd_q;
  assign out_rd_wen  = rd_wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch: x0 forcing, RAW bypass, WAW stall,
// back-pressure, flush and asynchronous reset.
module tb_operand_fetch;

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] ADD_X2_X1  = 32'h0010_8133;
  localparam logic [31:0] LUI_X3     = 32'h1234_51B7;
  localparam logic [31:0] ADDI_X4_1  = 32'h0010_0213;
  localparam logic [31:0] ADD_X5_X4  = 32'h0002_02B3;
  localparam logic [31:0] SW_X1_X2   = 32'h0011_2023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_instr;
  logic [4:0]  out_rd;
  logic        out_rd_wen;

  int vecs = 0;
  int errs = 0;

  operand_fetch #(.DATA_WIDTH(32), .REG_NUM(32), .REG_NUM_BIT(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_instr(out_instr),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    rf_rdata_a = '0; rf_rdata_b = '0; wb_wen = 1'b0; wb_waddr = '0;
    wb_wdata = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    vecs++; if ({out_pc, out_instr, out_rs1_val, out_rs2_val} !== 128'd0 || out_rd !== 5'd0 || out_rd_wen !== 1'b0) begin
      errs++; $display("FAIL reset_regs got pc=%h instr=%h rd=%0d wen=%0b want zeros", out_pc, out_instr, out_rd, out_rd_wen);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_x0_forced();
    in_valid = 1'b1; in_instr = ADDI_X1_5; in_pc = 32'h100; rf_rdata_a = 32'hDEAD;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got %0b want 1", in_ready); end
    vecs++; if (rf_raddr_a !== 5'd0) begin errs++; $display("FAIL x0_raddr got %0d want 0", rf_raddr_a); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL x0_valid got %0b want 1", out_valid); end
    vecs++; if (out_rs1_val !== 32'd0) begin errs++; $display("FAIL x0_rs1 got %h want 0", out_rs1_val); end
    vecs++; if (out_rd !== 5'd1 || out_rd_wen !== 1'b1 || out_pc !== 32'h100 || out_instr !== ADDI_X1_5) begin
      errs++; $display("FAIL x0_fields got rd=%0d wen=%0b pc=%h instr=%h want 1 1 100 %h", out_rd, out_rd_wen, out_pc, out_instr, ADDI_X1_5);
    end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL x0_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_raw_bypass();
    in_valid = 1'b1; in_instr = ADD_X2_X1; in_pc = 32'h104;
    rf_rdata_a = 32'h55; rf_rdata_b = 32'h66;
    for (int c = 0; c < 2; c++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL raw_stall%0d got %0b want 0", c, in_ready); end
      tick();
    end
    wb_wen = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'd7;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL raw_release got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0; wb_wen = 1'b0;
    vecs++; if (out_rs1_val !== 32'd7 || out_rs2_val !== 32'd7) begin
      errs++; $display("FAIL raw_bypass got %h/%h want 7/7", out_rs1_val, out_rs2_val);
    end
    vecs++; if (out_rd !== 5'd2) begin errs++; $display("FAIL raw_rd got %0d want 2", out_rd); end
    wb_wen = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'd0;
    tick();
    wb_wen = 1'b0;
  endtask

  task automatic test_waw();
    in_valid = 1'b1; in_instr = LUI_X3; in_pc = 32'h200;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL waw_first got %0b want 1", in_ready); end
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL waw_stall%0d got %0b want 0", c, in_ready); end
      tick();
    end
    wb_wen = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL waw_release got %0b want 1", in_ready); end
    tick();
    wb_wen = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL waw_set_wins got %0b want 0", in_ready); end
    in_valid = 1'b0;
    wb_wen = 1'b1; wb_waddr = 5'd3;
    tick();
    wb_wen = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_instr = SW_X1_X2; in_pc = 32'h300;
    rf_rdata_a = 32'h1111; rf_rdata_b = 32'h2222; out_ready = 1'b0;
    tick();
    vecs++; if (out_valid !== 1'b1 || out_rd_wen !== 1'b0 || out_rs1_val !== 32'h1111 || out_rs2_val !== 32'h2222) begin
      errs++; $display("FAIL bp_load got v=%0b wen=%0b %h/%h want 1 0 1111/2222", out_valid, out_rd_wen, out_rs1_val, out_rs2_val);
    end
    in_pc = 32'h304; rf_rdata_a = 32'h3333;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready%0d got %0b want 0", c, in_ready); end
      vecs++; if (out_pc !== 32'h300 || out_rs1_val !== 32'h1111 || out_valid !== 1'b1) begin
        errs++; $display("FAIL bp_hold%0d got pc=%h rs1=%h v=%0b want 300 1111 1", c, out_pc, out_rs1_val, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_release got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_pc !== 32'h304 || out_rs1_val !== 32'h3333) begin
      errs++; $display("FAIL bp_next got pc=%h rs1=%h want 304 3333", out_pc, out_rs1_val);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = ADDI_X4_1; in_pc = 32'h400;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; out_ready = 1'b1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %0b want 0", out_valid); end
    in_valid = 1'b1; in_instr = ADD_X5_X4; in_pc = 32'h404; rf_rdata_a = 32'h44;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_unpend got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_rs1_val !== 32'h44) begin
      errs++; $display("FAIL flush_next got v=%0b rd=%0d rs1=%h want 1 5 44", out_valid, out_rd, out_rs1_val);
    end
    wb_wen = 1'b1; wb_waddr = 5'd5;
    tick();
    wb_wen = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    in_valid = 1'b1; in_instr = ADDI_X1_5; in_pc = 32'h500;
    tick();
    in_instr = ADD_X2_X1; in_pc = 32'h504;
    #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_stall got %0b want 0", in_ready); end
    #1; rst_n = 1'b0; #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_async_valid got %0b want 0", out_valid); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_async_pend got %0b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_first_ready got %0b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_pc !== 32'h504) begin
      errs++; $display("FAIL rst_first_accept got v=%0b rd=%0d pc=%h want 1 2 504", out_valid, out_rd, out_pc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_x0_forced();
    test_raw_bypass();
    test_waw();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
